// File: rtl/rv_cpu.sv
// rv_cpu: single-cycle RV32I-subset core with built-in instruction ROM,
// data RAM and a 32x32 register file. Register x10 is exported as `result`.
module rv_cpu #(
  parameter int    IMEM_WORDS = 256,
  parameter int    DMEM_WORDS = 256,
  parameter string IMEM_INIT  = ""
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] result
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Default image: 5 + 7 -> a0, round-trip through RAM, double it, spin.
  logic [31:0] rom [IMEM_WORDS] = '{
    0: 32'h00500093,  // addi x1,x0,5
    1: 32'h00700113,  // addi x2,x0,7
    2: 32'h00208533,  // add  x10,x1,x2
    3: 32'h00A02023,  // sw   x10,0(x0)
    4: 32'h00002183,  // lw   x3,0(x0)
    5: 32'h00350533,  // add  x10,x10,x3
    6: 32'h0000006F,  // jal  x0,0
    default: 32'h00000000
  };

  logic [31:0] pc;
  logic [31:0] regs [32];
  logic [31:0] dmem [DMEM_WORDS];

  logic [31:0] instr;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] mem_addr, mem_rdata;
  logic [31:0] next_pc, rd_val;
  logic        rd_we, mem_we, taken;

  assign instr  = rom[pc[IAW+1:2]];
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // x0 is hardwired; it is never written, but also reads 0 before first reset.
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
  assign result  = regs[10];

  assign mem_addr  = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
  assign mem_rdata = dmem[mem_addr[DAW+1:2]];

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu = alt ? a - b : a + b;
      3'd1:    alu = a << b[4:0];
      3'd2:    alu = {31'd0, $signed(a) < $signed(b)};
      3'd3:    alu = {31'd0, a < b};
      3'd4:    alu = a ^ b;
      3'd5:    alu = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  // Branch condition; funct3 010/011 are not branches and never take.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'd0:    taken = (rs1_val == rs2_val);
      3'd1:    taken = (rs1_val != rs2_val);
      3'd4:    taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'd5:    taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'd6:    taken = (rs1_val <  rs2_val);
      3'd7:    taken = (rs1_val >= rs2_val);
      default: taken = 1'b0;
    endcase
  end

  // Decode/execute: pick write-back value, store enable and next PC.
  // Anything not recognised falls through as a NOP.
  always_comb begin
    rd_we   = 1'b0;
    rd_val  = 32'd0;
    mem_we  = 1'b0;
    next_pc = pc + 32'd4;
    case (opcode)
      OPC_LUI: begin
        rd_we  = 1'b1;
        rd_val = imm_u;
      end
      OPC_AUIPC: begin
        rd_we  = 1'b1;
        rd_val = pc + imm_u;
      end
      OPC_JAL: begin
        rd_we   = 1'b1;
        rd_val  = pc + 32'd4;
        next_pc = pc + imm_j;
      end
      OPC_JALR: if (funct3 == 3'd0) begin
        rd_we   = 1'b1;
        rd_val  = pc + 32'd4;
        next_pc = (rs1_val + imm_i) & ~32'd1;
      end
      OPC_BRANCH: if (taken) next_pc = pc + imm_b;
      OPC_LOAD: if (funct3 == 3'd2) begin
        rd_we  = 1'b1;
        rd_val = mem_rdata;
      end
      OPC_STORE: if (funct3 == 3'd2) mem_we = 1'b1;
      OPC_OPIMM: begin
        // Shift-immediates carry a funct7 that must be legal; others use it as imm.
        if ((funct3 == 3'd1 && funct7 == 7'd0) ||
            (funct3 == 3'd5 && (funct7 == 7'd0 || funct7 == 7'b0100000)) ||
            (funct3 != 3'd1 && funct3 != 3'd5)) begin
          rd_we  = 1'b1;
          rd_val = alu(rs1_val, imm_i, funct3, (funct3 == 3'd5) && instr[30]);
        end
      end
      OPC_OP: begin
        if (funct7 == 7'd0 ||
            (funct7 == 7'b0100000 && (funct3 == 3'd0 || funct3 == 3'd5))) begin
          rd_we  = 1'b1;
          rd_val = alu(rs1_val, rs2_val, funct3, instr[30]);
        end
      end
      default: ;
    endcase
  end

  // Architectural state: PC and register file; reset aborts the retiring write.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= 32'd0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else begin
      if (rd_we && rd != 5'd0) regs[rd] <= rd_val;
      pc <= next_pc;
    end
  end

  // Data RAM write port; contents survive reset but no store lands during it.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) dmem[mem_addr[DAW+1:2]] <= rs2_val;
  end

  logic unused_bits;
  assign unused_bits = ^{pc[1:0], pc[31:IAW+2], mem_addr[1:0], mem_addr[31:DAW+2]};

endmodule

// File: tb/tb_rv_cpu.sv
// tb_rv_cpu: directed programs loaded into the ROM during reset, with
// hand-computed a0 values checked after fixed numbers of clock edges.
module tb_rv_cpu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] result;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] prog [$];

  rv_cpu dut (.clk(clk), .rst(rst), .result(result));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Retire n instructions, then sample just after the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges while the ROM is rewritten with `prog`.
  task automatic load;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 64; i++) dut.rom[i] = (i < prog.size()) ? prog[i] : 32'h0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset with built-in program
    step(2);
    chk("reset_result", result, 32'd0);
    chk("reset_pc", dut.pc, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(2);  chk("dflt_e2", result, 32'd0);
    step(1);  chk("dflt_e3", result, 32'd12);
    step(3);  chk("dflt_e6", result, 32'd24);
    step(4);  chk("dflt_e10", result, 32'd24);

    // Mid-run reset
    @(negedge clk);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(4);
    rst = 1'b1;
    step(1);  chk("midrst_clear", result, 32'd0);
    rst = 1'b0;
    step(3);  chk("midrst_e3", result, 32'd12);
    step(3);  chk("midrst_e6", result, 32'd24);

    // ALU
    prog = '{32'hFFF00093,   // addi x1,x0,-1
             32'h01C0D513,   // srli x10,x1,28
             32'h41C0D513,   // srai x10,x1,28
             32'h00300113,   // addi x2,x0,3
             32'h00500193,   // addi x3,x0,5
             32'h40310533,   // sub  x10,x2,x3
             32'h00312533,   // slt  x10,x2,x3
             32'h0020B533,   // sltu x10,x1,x2
             32'h0020C533,   // xor  x10,x1,x2
             32'h00311533};  // sll  x10,x2,x3
    load();
    step(2);  chk("srli", result, 32'h0000000F);
    step(1);  chk("srai", result, 32'hFFFFFFFF);
    step(3);  chk("sub", result, 32'hFFFFFFFE);
    step(1);  chk("slt", result, 32'd1);
    step(1);  chk("sltu", result, 32'd0);
    step(1);  chk("xor", result, 32'hFFFFFFFC);
    step(1);  chk("sll", result, 32'h00000060);

    // Branches
    prog = '{32'h00100093, 32'h00008463, 32'h00900513, 32'h00150513};  // beq not taken
    load();
    step(4);  chk("beq_nt", result, 32'd10);
    prog = '{32'h00100093, 32'h00009463, 32'h00900513, 32'h00150513};  // bne taken
    load();
    step(3);  chk("bne_t", result, 32'd1);
    step(1);  chk("bne_t_hold", result, 32'd1);
    prog = '{32'hFFF00093, 32'h0000C463, 32'h00900513, 32'h00150513};  // blt -1<0 taken
    load();
    step(3);  chk("blt_t", result, 32'd1);
    prog = '{32'hFFF00093, 32'h0000E463, 32'h00900513, 32'h00150513};  // bltu not taken
    load();
    step(4);  chk("bltu_nt", result, 32'd10);

    // Jumps, LUI, x0, AUIPC
    prog = '{32'h0080056F};  // jal x10,+8
    load();
    step(1);  chk("jal_link", result, 32'd4);
    chk("jal_pc", dut.pc, 32'd8);
    prog = '{32'h12345537, 32'h00700013, 32'h00000533};  // lui; addi x0; add x10,x0,x0
    load();
    step(1);  chk("lui", result, 32'h12345000);
    step(2);  chk("x0_zero", result, 32'd0);
    prog = '{32'h00D00093, 32'h00408567, 32'h00900513, 32'h00900513, 32'h00150513};
    load();
    step(2);  chk("jalr_link", result, 32'd8);
    chk("jalr_pc", dut.pc, 32'd16);
    step(1);  chk("jalr_tgt", result, 32'd9);
    prog = '{32'h00000013, 32'h00001517};  // nop; auipc x10,1
    load();
    step(2);  chk("auipc", result, 32'h00001004);

    // Memory, with an unsupported opcode in between and address wrap
    prog = '{32'hDEADC0B7,   // lui  x1,0xDEADC
             32'hEEF08093,   // addi x1,x1,-273
             32'h04102023,   // sw   x1,0x40(x0)
             32'hFFFFFFFF,   // unsupported
             32'h04002503,   // lw   x10,0x40(x0)
             32'h00000513,   // addi x10,x0,0
             32'h44202503};  // lw   x10,0x442(x0) -> same word after wrap
    load();
    step(5);  chk("sw_lw", result, 32'hDEADBEEF);
    step(1);  chk("clear_a0", result, 32'd0);
    step(1);  chk("lw_wrap", result, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
